bram_scan_sequencer: RTL
========================

BRAM_SCAN_SEQUENCER -- requirements
Module: bram_scan_sequencer

Interface
REQ-001 Parameter ADDR_W, default 4: BRAM address width; depth = 2^ADDR_W words.
REQ-002 Parameter SEED, default 8'h0A: fill-pattern base value.
REQ-003 Parameter HOLD_CYCLES, default 50_000_000: clk cycles each read-back word is held for display; minimum 1.
REQ-004 clk  in  1  system clock, all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  single-cycle pulse; begins a fill+scan pass.
REQ-007 wr_en  out  1  BRAM write strobe.
REQ-008 wr_addr  out  ADDR_W  BRAM write address.
REQ-009 wr_data  out  8  BRAM write data.
REQ-010 rd_en  out  1  BRAM read strobe.
REQ-011 rd_addr  out  ADDR_W  BRAM read address.
REQ-012 rd_data  in  8  BRAM read data, valid exactly 1 cycle after rd_en.
REQ-013 disp_value  out  8  word currently held for the display stage.
REQ-014 disp_addr  out  ADDR_W  address of disp_value.
REQ-015 busy  out  1  high from start acceptance until DONE entered.
REQ-016 done  out  1  high in DONE state.
REQ-017 error  out  1  sticky mismatch flag (see Configuration).

Function
REQ-018 FSM states SHALL be IDLE, FILL, RD_REQ, RD_CAP, HOLD, DONE.
REQ-019 IDLE: start=1 -> FILL, address counter cleared to 0, error cleared; start ignored in every other state except DONE.
REQ-020 FILL: wr_en=1 every cycle, wr_addr=counter, wr_data=(SEED+counter) mod 256; counter increments; after address 2^ADDR_W-1 -> RD_REQ with counter=0 (fill takes exactly 2^ADDR_W cycles).
REQ-021 RD_REQ: rd_en=1 for one cycle, rd_addr=counter -> RD_CAP.
REQ-022 RD_CAP: disp_value<=rd_data, disp_addr<=counter, hold counter loaded with HOLD_CYCLES-1 -> HOLD.
REQ-023 HOLD: hold counter decrements; at 0, if counter=2^ADDR_W-1 -> DONE, else counter+1 and -> RD_REQ.
REQ-024 DONE: done=1, disp_value keeps last word; start=1 -> FILL (restart pass identical to IDLE start).
REQ-025 wr_en and rd_en SHALL never be high in the same cycle; both low outside FILL/RD_REQ.
REQ-026 Address counter SHALL wrap modulo 2^ADDR_W; no address beyond depth is ever driven.
REQ-027 wr_data addition SHALL be 8-bit with carry discarded (e.g. SEED=8'hFF, addr 1 -> 8'h00).
REQ-028 busy=1 in FILL, RD_REQ, RD_CAP, HOLD; 0 in IDLE and DONE.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, counters 0, wr_en=rd_en=0, wr_addr=rd_addr=0, wr_data=0, disp_value=0, disp_addr=0, busy=done=error=0.
REQ-030 Reset asserted mid-pass SHALL abort the pass; after release the block waits in IDLE for a new start.

Configuration
REQ-031 With macro BRAM_SCAN_VERIFY_EN defined, in RD_CAP the block SHALL compare rd_data to (SEED+counter) mod 256 and set error=1 on mismatch, sticky until next start or reset.
REQ-032 Without BRAM_SCAN_VERIFY_EN, error SHALL be constant 0 and no compare logic synthesised.

Verification
REQ-033 Reset, start pulse, ADDR_W=4, SEED=8'h0A, HOLD_CYCLES=4 -> 16 writes addr 0..15 data 8'h0A..8'h19, then disp_value steps 8'h0A..8'h19, each held 4 cycles, done=1, error=0.
REQ-034 Model BRAM returns 8'h00 at addr 5 with BRAM_SCAN_VERIFY_EN -> error rises in RD_CAP of addr 5, stays 1 through DONE; without macro error stays 0.
REQ-035 rst_n pulsed low during HOLD of addr 7 -> all outputs 0 within same cycle, IDLE, no further strobes until next start.
REQ-036 start pulsed during FILL and HOLD -> ignored, pass sequence unchanged; start in DONE -> new pass begins next cycle.
REQ-037 SEED=8'hF8 -> wr_data wraps 8'hFF to 8'h00 at addr 8, readback matches, error=0.
REQ-038 Every cycle of all tests: wr_en & rd_en never both 1; busy=0 exactly in IDLE/DONE.

Source files
------------

// File: rtl/bram_scan_sequencer.sv
// rtl/bram_scan_sequencer.sv - BRAM fill-then-scan sequencer with held read-back display
//
// Purpose: on a start pulse, write (SEED + addr) mod 256 to every BRAM word,
// then read each word back in address order. Each word is held on
// disp_value/disp_addr for HOLD_CYCLES clocks. When the last word's hold
// expires, the block sits in DONE until the next start.
//
// Optional feature: define BRAM_SCAN_VERIFY_EN to compare each read-back word
// against the fill pattern. A mismatch sets a sticky error flag. Without the
// macro, error is tied to 0.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               single-cycle pulse; accepted in IDLE and DONE only
//   wr_en/addr/data     BRAM write port, driven during FILL
//   rd_en/addr          BRAM read request, driven during RD_REQ
//   rd_data             BRAM read data, valid the cycle after rd_en
//   disp_value/addr     word currently held for display, and its address
//   busy, done, error   status flags
module bram_scan_sequencer #(
  parameter int          ADDR_W      = 4,
  parameter logic [7:0]  SEED        = 8'h0A,
  parameter int          HOLD_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [7:0]        disp_value,
  output logic [ADDR_W-1:0] disp_addr,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // The hold counter only ever holds HOLD_CYCLES-1 down to 0.
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    RD_REQ,
    RD_CAP,
    HOLD,
    DONE
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              last_addr;
  logic              start_ok;
  logic [7:0]        fill_value;

  assign last_addr  = &addr_cnt;
  assign start_ok   = start && ((state == IDLE) || (state == DONE));
  // The 8-bit add discards the carry, so the pattern wraps from 8'hFF to 8'h00.
  assign fill_value = SEED + 8'(addr_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = FILL;
      end
      FILL: begin
        wr_en   = 1'b1;
        wr_addr = addr_cnt;
        wr_data = fill_value;
        busy    = 1'b1;
        if (last_addr) state_nxt = RD_REQ;
      end
      RD_REQ: begin
        rd_en     = 1'b1;
        rd_addr   = addr_cnt;
        busy      = 1'b1;
        state_nxt = RD_CAP;
      end
      RD_CAP: begin
        busy      = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        busy = 1'b1;
        if (hold_cnt == '0) state_nxt = last_addr ? DONE : RD_REQ;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = FILL;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address counter, hold timer and the display registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt   <= '0;
      hold_cnt   <= '0;
      disp_value <= '0;
      disp_addr  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) addr_cnt <= '0;
        end
        FILL: begin
          // The counter wraps to 0 after the last write, ready for the scan.
          addr_cnt <= addr_cnt + 1'b1;
        end
        RD_CAP: begin
          disp_value <= rd_data;
          disp_addr  <= addr_cnt;
          hold_cnt   <= HOLD_LOAD;
        end
        HOLD: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
          end else if (!last_addr) begin
            addr_cnt <= addr_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BRAM_SCAN_VERIFY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error <= 1'b0;
    end else if (start_ok) begin
      error <= 1'b0;
    end else if ((state == RD_CAP) && (rd_data != fill_value)) begin
      error <= 1'b1;
    end
  end
`else
  assign error = 1'b0;
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule
